// File: rtl/tpu_pkg.sv
// Shared TPU constants, the C reader state encoding and the C word lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tpu_pkg;

    localparam int DATA_W = 32;               // one C element / output beat
    localparam int LANES  = 4;                // elements per C SRAM word
    localparam int DIM_W  = 8;                // width of M, N
    localparam int IDX_W  = 16;               // C SRAM word index width
    localparam int WORD_W = DATA_W * LANES;   // C SRAM word width (128)
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_CAP    = 3'd2,
        ST_STREAM = 3'd3,
        ST_CLR    = 3'd4,
        ST_DONE   = 3'd5
    } rd_state_e;

    // Lane 0 lives in the most significant 32 bits of a C word.
    function automatic logic [DATA_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                     input logic [LANE_W-1:0] lane);
        lane_slice = word[WORD_W-1-DATA_W*int'(lane) -: DATA_W];
    endfunction

    // C is stored column-tile major: each word holds 4 adjacent columns of one row.
    function automatic logic [IDX_W-1:0] c_word_addr(input logic [DIM_W-1:0] m,
                                                     input logic [DIM_W-1:0] n,
                                                     input logic [DIM_W-1:0] rows);
        c_word_addr = IDX_W'(n >> 2) * IDX_W'(rows) + IDX_W'(m);
    endfunction

endpackage

// File: rtl/tpu_c_word_buf.sv
// Holds one captured C word and selects the current lane for the output beat.
// Latency: word available the cycle after cap; lane mux is combinational from registers.
// Backpressure: word and lane only change on cap/adv, so the beat is stable while stalled.
// Ports: clk, rst_n (sync, active-low); cap loads word_in and lane_init; adv steps to the
//        next lane; lane/dat give the current lane index and its 32-bit element.
module tpu_c_word_buf
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap,
    input  logic [LANE_W-1:0] lane_init,
    input  logic              adv,
    input  logic [WORD_W-1:0] word_in,
    output logic [LANE_W-1:0] lane,
    output logic [DATA_W-1:0] dat
);

    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            lane   <= '0;
        end else if (cap) begin
            word_q <= word_in;
            lane   <= lane_init;
        end else if (adv) begin
            lane   <= lane + 1'b1;
        end
    end

    assign dat = lane_slice(word_q, lane);

endmodule

// File: rtl/tpu_c_reader.sv
// Drains the C result SRAM after a job and streams C[m][n] row-major to the host.
// Latency: start -> first beat valid 3 cycles; each further word costs 2 bubbles (3 with clear).
// Backpressure: valid/ready; beat data/row/col/last held stable while out_ready is low.
// Ports: clk, rst_n (sync, active-low); start/M/N job request; busy status;
//        C_wr_en/C_index/C_data_in/C_data_out C SRAM port (1-cycle read latency);
//        out_valid/out_ready/out_data/out_row/out_col/out_last result stream.
// Build option: TPU_C_READER_CLEAR_EN zeroes each C word after its last beat is accepted.
module tpu_c_reader
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  M,
    input  logic [DIM_W-1:0]  N,
    output logic              busy,
    output logic              C_wr_en,
    output logic [IDX_W-1:0]  C_index,
    output logic [WORD_W-1:0] C_data_in,
    input  logic [WORD_W-1:0] C_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              out_last
);

    rd_state_e         state;
    logic [DIM_W-1:0]  m_q, n_q, rows_q, cols_q;
    logic [DIM_W-1:0]  m_nxt, n_nxt;
    logic [LANE_W-1:0] lane;
    logic              hs, row_end, word_end;
`ifdef TPU_C_READER_CLEAR_EN
    logic              last_q;   // the word being cleared held the final beat
`endif

    assign hs       = (state == ST_STREAM) && out_ready;
    assign row_end  = (n_q == cols_q - 1'b1);
    assign word_end = row_end || (lane == LANE_W'(LANES - 1));
    assign m_nxt    = row_end ? m_q + 1'b1 : m_q;
    assign n_nxt    = row_end ? '0 : n_q + 1'b1;

    assign out_valid = (state == ST_STREAM);
    assign out_row   = m_q;
    assign out_col   = n_q;
    assign out_last  = out_valid && (m_q == rows_q - 1'b1) && row_end;
    assign C_data_in = '0;
`ifdef TPU_C_READER_CLEAR_EN
    assign C_wr_en   = (state == ST_CLR);
`else
    assign C_wr_en   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            C_index <= '0;
`ifdef TPU_C_READER_CLEAR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            // Registered one cycle behind the state so busy covers DONE plus one cycle.
            busy <= (state != ST_IDLE) || start;
            case (state)
                ST_IDLE: if (start) begin
                    rows_q <= M;
                    cols_q <= N;
                    m_q    <= '0;
                    n_q    <= '0;
                    if (M == '0 || N == '0) begin
                        state <= ST_DONE;       // empty matrix: no SRAM access
                    end else begin
                        state   <= ST_RD;
                        C_index <= '0;
                    end
                end
                ST_RD:  state <= ST_CAP;
                ST_CAP: state <= ST_STREAM;
                ST_STREAM: if (hs) begin
                    m_q <= m_nxt;
                    n_q <= n_nxt;
                    if (word_end) begin
`ifdef TPU_C_READER_CLEAR_EN
                        // C_index still points at the finished word; CLR writes it.
                        state  <= ST_CLR;
                        last_q <= out_last;
`else
                        if (out_last) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_RD;
                            C_index <= c_word_addr(m_nxt, n_nxt, rows_q);
                        end
`endif
                    end
                end
`ifdef TPU_C_READER_CLEAR_EN
                ST_CLR: begin
                    if (last_q) begin
                        state <= ST_DONE;
                    end else begin
                        state   <= ST_RD;
                        C_index <= c_word_addr(m_q, n_q, rows_q);
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    tpu_c_word_buf u_word_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (state == ST_CAP),
        .lane_init (n_q[LANE_W-1:0]),
        .adv       (hs && !word_end),
        .word_in   (C_data_out),
        .lane      (lane),
        .dat       (out_data)
    );

endmodule
